// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end for one shared subtractive GCD engine.
// A granted requester's operands are reduced one subtract per cycle and its done bit pulses with the result.
module gcd_rr_scheduler #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_in,
    input  logic [NREQ*WIDTH-1:0]   b_in,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        result,
    output logic                    busy
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_n;
    logic [WIDTH-1:0]  ra_r, ra_n;
    logic [WIDTH-1:0]  rb_r, rb_n;
    logic [IDXW-1:0]   id_r, id_n;
    logic [IDXW-1:0]   ptr_r, ptr_n;
    logic [WIDTH-1:0]  result_n;
    logic [NREQ-1:0]   gnt_n;
    logic [NREQ-1:0]   done_n;
    logic              busy_n;
    logic              found_s;
    logic [IDXW-1:0]   sel_s;

    // Round-robin search: first set req bit starting at ptr, wrapping.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && req[(int'(ptr_r) + k) % NREQ]) begin
                found_s = 1'b1;
                sel_s   = IDXW'((int'(ptr_r) + k) % NREQ);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_n  = state_r;
        ra_n     = ra_r;
        rb_n     = rb_r;
        id_n     = id_r;
        ptr_n    = ptr_r;
        result_n = result;
        gnt_n    = '0;
        done_n   = '0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    gnt_n   = NREQ'(1) << sel_s;
                    ra_n    = a_in[int'(sel_s)*WIDTH +: WIDTH];
                    rb_n    = b_in[int'(sel_s)*WIDTH +: WIDTH];
                    id_n    = sel_s;
                    ptr_n   = (sel_s == IDXW'(NREQ - 1)) ? '0 : sel_s + IDXW'(1);
                    state_n = CALC;
                end else begin
                    state_n = IDLE;
                end
            end
            CALC: begin
                // A zero operand means the other one is the GCD; equal values fall to the rb branch.
                if ((ra_r == '0) || (rb_r == '0)) begin
                    result_n = (ra_r == '0) ? rb_r : ra_r;
                    done_n   = NREQ'(1) << id_r;
                    state_n  = DONE;
                end else if (ra_r > rb_r) begin
                    ra_n = ra_r - rb_r;
                end else begin
                    rb_n = rb_r - ra_r;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ra_r    <= '0;
            rb_r    <= '0;
            id_r    <= '0;
            ptr_r   <= '0;
            result  <= '0;
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_n;
            ra_r    <= ra_n;
            rb_r    <= rb_n;
            id_r    <= id_n;
            ptr_r   <= ptr_n;
            result  <= result_n;
            gnt     <= gnt_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// Directed bench for gcd_rr_scheduler: drivers push expected grants/results into queues,
// a negedge monitor pops and compares whenever gnt or done pulses.
module tb_gcd_rr_scheduler;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [W-1:0]   result;
    logic           busy;

    typedef struct {
        int id;
        int res;
        int lat;
    } exp_t;

    exp_t eq[$];
    int   gq[$];
    int   gnt_cyc[N];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   m_gid;
    int   m_did;
    exp_t m_e;

    gcd_rr_scheduler #(.WIDTH(W), .NREQ(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a_in   (a_in),
        .b_in   (b_in),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int first_bit(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Monitor: every gnt/done pulse is matched against the scoreboard queues.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (gnt != '0) begin
                m_gid = first_bit(gnt);
                check("gnt_onehot", int'($onehot(gnt)), 1);
                check("gnt_done_overlap", int'(done != '0), 0);
                if (gq.size() == 0) check("unexpected_gnt", m_gid, -1);
                else check("gnt_order", m_gid, gq.pop_front());
                gnt_cyc[m_gid] = cyc;
            end
            if (done != '0) begin
                m_did = first_bit(done);
                check("done_onehot", int'($onehot(done)), 1);
                if (eq.size() == 0) begin
                    check("unexpected_done", m_did, -1);
                end else begin
                    m_e = eq.pop_front();
                    check("done_id", m_did, m_e.id);
                    check("result", int'(result), m_e.res);
                    check("latency", cyc - gnt_cyc[m_did], m_e.lat);
                    check("busy_at_done", int'(busy), 1);
                end
            end
        end
    end

    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic wait_gnt(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt[i] !== 1'b1 && n < 100);
        check($sformatf("gnt%0d_seen", i), int'(gnt[i] === 1'b1), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy !== 1'b0 || eq.size() != 0) && n < 300);
        check("idle_reached", int'(busy === 1'b0 && eq.size() == 0), 1);
        @(negedge clk);
    endtask

    task automatic job(input int i, input int a, input int b, input int res, input int lat);
        gq.push_back(i);
        eq.push_back('{i, res, lat});
        set_ops(i, a, b);
        req[i] = 1'b1;
        wait_gnt(i);
        check("busy_after_gnt", int'(busy), 1);
        req[i] = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", int'(gnt), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Latency = subtract steps + 1: (8,6) takes 4 steps, (15,7) takes 9 (incl. (1,1)->(1,0)).
        job(0, 8, 6, 2, 5);
        job(2, 15, 7, 1, 10);
        job(2, 0, 9, 9, 1);
        job(2, 0, 0, 0, 1);
        job(2, 5, 5, 5, 2);

        // Operands changed after the grant must not affect the result.
        gq.push_back(1);
        eq.push_back('{1, 3, 4});
        set_ops(1, 9, 6);
        req[1] = 1'b1;
        wait_gnt(1);
        req[1] = 1'b0;
        @(negedge clk);
        set_ops(1, 15, 1);
        wait_idle();

        // Reset in the middle of a long (15,1) job: no done may follow.
        gq.push_back(0);
        set_ops(0, 15, 1);
        req[0] = 1'b1;
        wait_gnt(0);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_gnt", int'(gnt), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_result", int'(result), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // ptr is back at 0, so requester 1 wins over 3.
        gq.push_back(1);
        gq.push_back(3);
        eq.push_back('{1, 4, 4});
        eq.push_back('{3, 3, 4});
        set_ops(1, 12, 8);
        set_ops(3, 9, 6);
        req = 4'b1010;
        wait_gnt(1);
        req[1] = 1'b0;
        wait_gnt(3);
        req[3] = 1'b0;
        wait_idle();

        // All four held high: grants rotate 0,1,2,3,0.
        set_ops(0, 6, 4);
        set_ops(1, 7, 0);
        set_ops(2, 9, 3);
        set_ops(3, 10, 4);
        foreach (gq[i]) gq.delete(i);
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
        eq.push_back('{0, 2, 4});
        eq.push_back('{1, 7, 1});
        eq.push_back('{2, 3, 4});
        eq.push_back('{3, 2, 5});
        eq.push_back('{0, 2, 4});
        req = 4'b1111;
        wait_gnt(0);
        wait_gnt(1);
        wait_gnt(2);
        wait_gnt(3);
        wait_gnt(0);
        req = 4'b0000;
        wait_idle();

        // req0 held permanently; req3 raised mid-job must be served before 0 again.
        set_ops(0, 8, 6);
        set_ops(3, 12, 8);
        gq.push_back(0); gq.push_back(3); gq.push_back(0);
        eq.push_back('{0, 2, 5});
        eq.push_back('{3, 4, 4});
        eq.push_back('{0, 2, 5});
        req[0] = 1'b1;
        wait_gnt(0);
        @(negedge clk);
        req[3] = 1'b1;
        wait_gnt(3);
        req[3] = 1'b0;
        wait_gnt(0);
        req[0] = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        check("queues_drained", gq.size() + eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
